// File: rtl/alu_seq64_if.sv
// Request/response bundle between an issuing agent and the sequential 64-bit ALU.
// The issuer drives start with the operation; the ALU returns status and the registered result.
interface alu_seq64_if;
  logic        start;
  logic [11:0] alu_control;
  logic [63:0] alu_src1;
  logic [63:0] alu_src2;
  logic        busy;
  logic        done;
  logic [63:0] alu_result;
  logic        illegal;

  modport master (
    output start, alu_control, alu_src1, alu_src2,
    input  busy, done, alu_result, illegal
  );

  modport slave (
    input  start, alu_control, alu_src1, alu_src2,
    output busy, done, alu_result, illegal
  );
endinterface

// File: rtl/alu_seq64.sv
// Multi-cycle 64-bit ALU: arithmetic/logic through a shared 32-bit half datapath (LO then HI),
// shifts one bit per cycle, one-cycle done pulse with a held, registered result.
module alu_seq64 (
  input  logic         clk,
  input  logic         reset,
  alu_seq64_if.slave   bus
);

  localparam int unsigned W  = 64;
  localparam int unsigned HW = 32;
  localparam int unsigned CW = 12;
  localparam int unsigned SW = 6;

  localparam int unsigned C_ADD  = 11;
  localparam int unsigned C_SUB  = 10;
  localparam int unsigned C_SLT  = 9;
  localparam int unsigned C_SLTU = 8;
  localparam int unsigned C_AND  = 7;
  localparam int unsigned C_NOR  = 6;
  localparam int unsigned C_OR   = 5;
  localparam int unsigned C_XOR  = 4;
  localparam int unsigned C_SLL  = 3;
  localparam int unsigned C_SRL  = 2;
  localparam int unsigned C_SRA  = 1;
  localparam int unsigned C_LUI  = 0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LO    = 3'd1,
    S_HI    = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t         r_state;
  logic [CW-1:0]  r_ctrl;
  logic [W-1:0]   r_src1;
  logic [W-1:0]   r_src2;
  logic [W-1:0]   r_work;
  logic [SW-1:0]  r_cnt;
  logic           r_carry;
  logic [HW-1:0]  r_lo;
  logic           r_busy;
  logic           r_done;
  logic [W-1:0]   r_result;
  logic           r_illegal;

  logic           w_onehot;
  logic           w_start_shift;
  logic           w_hi_phase;
  logic           w_sub;
  logic [HW-1:0]  w_a;
  logic [HW-1:0]  w_b;
  logic [HW-1:0]  w_bx;
  logic           w_cin;
  logic [HW:0]    w_sum;
  logic           w_ovf;
  logic [HW-1:0]  w_half;
  logic [W-1:0]   w_hi_result;
  logic [W-1:0]   w_shift_next;

  // Legality is judged on the control word being latched this cycle.
  assign w_onehot      = (bus.alu_control != '0) &&
                         ((bus.alu_control & (bus.alu_control - CW'(1))) == '0);
  assign w_start_shift = bus.alu_control[C_SLL] | bus.alu_control[C_SRL] |
                         bus.alu_control[C_SRA];

  // Shared half-width adder: low half in LO, high half in HI with the registered carry.
  assign w_hi_phase = (r_state == S_HI);
  assign w_sub      = r_ctrl[C_SUB] | r_ctrl[C_SLT] | r_ctrl[C_SLTU];
  assign w_a        = w_hi_phase ? r_src1[W-1:HW] : r_src1[HW-1:0];
  assign w_b        = w_hi_phase ? r_src2[W-1:HW] : r_src2[HW-1:0];
  assign w_bx       = w_sub ? ~w_b : w_b;
  assign w_cin      = w_hi_phase ? r_carry : w_sub;
  assign w_sum      = {1'b0, w_a} + {1'b0, w_bx} + (HW+1)'(w_cin);
  assign w_ovf      = (w_a[HW-1] == w_bx[HW-1]) && (w_sum[HW-1] != w_a[HW-1]);

  always_comb begin
    w_half = '0;
    if (r_ctrl[C_ADD] | w_sub)  w_half = w_sum[HW-1:0];
    else if (r_ctrl[C_AND])     w_half = w_a & w_b;
    else if (r_ctrl[C_NOR])     w_half = ~(w_a | w_b);
    else if (r_ctrl[C_OR])      w_half = w_a | w_b;
    else if (r_ctrl[C_XOR])     w_half = w_a ^ w_b;
    else if (r_ctrl[C_LUI])     w_half = w_hi_phase ? r_src2[HW-1:0] : '0;
  end

  // Compares only need the top-half sign, overflow and carry-out.
  always_comb begin
    w_hi_result = {w_half, r_lo};
    if (r_ctrl[C_SLT])       w_hi_result = {{(W-1){1'b0}}, w_sum[HW-1] ^ w_ovf};
    else if (r_ctrl[C_SLTU]) w_hi_result = {{(W-1){1'b0}}, ~w_sum[HW]};
  end

  always_comb begin
    w_shift_next = r_work;
    if (r_ctrl[C_SLL])      w_shift_next = {r_work[W-2:0], 1'b0};
    else if (r_ctrl[C_SRL]) w_shift_next = {1'b0, r_work[W-1:1]};
    else if (r_ctrl[C_SRA]) w_shift_next = {r_work[W-1], r_work[W-1:1]};
  end

  // Control FSM and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_ctrl    <= '0;
      r_src1    <= '0;
      r_src2    <= '0;
      r_work    <= '0;
      r_cnt     <= '0;
      r_carry   <= 1'b0;
      r_lo      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_ctrl <= bus.alu_control;
            r_src1 <= bus.alu_src1;
            r_src2 <= bus.alu_src2;
            r_busy <= 1'b1;
            if (!w_onehot) begin
              r_result  <= '0;
              r_illegal <= 1'b1;
              r_done    <= 1'b1;
              r_state   <= S_DONE;
            end else if (w_start_shift) begin
              r_work  <= bus.alu_src2;
              r_cnt   <= bus.alu_src1[SW-1:0];
              r_state <= S_SHIFT;
            end else begin
              r_state <= S_LO;
            end
          end
        end
        S_LO: begin
          r_lo    <= w_half;
          r_carry <= w_sum[HW];
          r_state <= S_HI;
        end
        S_HI: begin
          r_result  <= w_hi_result;
          r_illegal <= 1'b0;
          r_done    <= 1'b1;
          r_state   <= S_DONE;
        end
        S_SHIFT: begin
          if (r_cnt != '0) begin
            r_work <= w_shift_next;
            r_cnt  <= r_cnt - SW'(1);
          end else begin
            r_result  <= r_work;
            r_illegal <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.alu_result = r_result;
  assign bus.illegal    = r_illegal;

endmodule

// File: tb/tb_alu_seq64.sv
// Directed bench for alu_seq64: latency, results and flags checked against hand-computed values.
module tb_alu_seq64;

  localparam logic [11:0] OP_ADD  = 12'h800;
  localparam logic [11:0] OP_SUB  = 12'h400;
  localparam logic [11:0] OP_SLT  = 12'h200;
  localparam logic [11:0] OP_SLTU = 12'h100;
  localparam logic [11:0] OP_AND  = 12'h080;
  localparam logic [11:0] OP_NOR  = 12'h040;
  localparam logic [11:0] OP_OR   = 12'h020;
  localparam logic [11:0] OP_XOR  = 12'h010;
  localparam logic [11:0] OP_SLL  = 12'h008;
  localparam logic [11:0] OP_SRL  = 12'h004;
  localparam logic [11:0] OP_SRA  = 12'h002;
  localparam logic [11:0] OP_LUI  = 12'h001;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  alu_seq64_if bus ();

  alu_seq64 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op at a falling edge; lat = cycle index (start sampled in cycle 0) of done, -1 on timeout.
  task automatic run_op(input logic [11:0] ctrl, input logic [63:0] s1, input logic [63:0] s2,
                        input bit scramble, output int lat);
    @(negedge clk);
    bus.start       = 1'b1;
    bus.alu_control = ctrl;
    bus.alu_src1    = s1;
    bus.alu_src2    = s2;
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (scramble && c == 1) begin
        bus.alu_control = OP_SUB;
        bus.alu_src1    = ~s1;
        bus.alu_src2    = 64'hDEAD_BEEF_0BAD_F00D;
      end
      if (bus.done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.start = 1'b1;
    bus.alu_control = OP_ADD;
    bus.alu_src1 = 64'h1;
    bus.alu_src2 = 64'h2;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
    checks++; if (bus.alu_result !== 64'h0) begin errors++; $display("FAIL reset_result got %h exp 0", bus.alu_result); end
    checks++; if (bus.illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b exp 0", bus.illegal); end
    reset = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b exp 0", bus.busy); end
  endtask

  task automatic test_add_carry;
    int lat;
    run_op(OP_ADD, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL add_latency got %0d exp 3", lat); end
    checks++; if (bus.alu_result !== 64'h0000_0001_0000_0000) begin errors++; $display("FAIL add_carry got %h exp 0000000100000000", bus.alu_result); end
    checks++; if (bus.illegal !== 1'b0) begin errors++; $display("FAIL add_illegal got %b exp 0", bus.illegal); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL done_busy got %b exp 1", bus.busy); end
  endtask

  task automatic test_compare;
    int lat;
    run_op(OP_SLT, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, lat);
    checks++; if (bus.alu_result !== 64'h1) begin errors++; $display("FAIL slt_neg got %h exp 1", bus.alu_result); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL slt_latency got %0d exp 3", lat); end
    run_op(OP_SLTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, lat);
    checks++; if (bus.alu_result !== 64'h0) begin errors++; $display("FAIL sltu_big got %h exp 0", bus.alu_result); end
    run_op(OP_SLT, 64'h8000_0000_0000_0000, 64'h1, 1'b0, lat);
    checks++; if (bus.alu_result !== 64'h1) begin errors++; $display("FAIL slt_overflow got %h exp 1", bus.alu_result); end
    run_op(OP_SLT, 64'h5, 64'h3, 1'b0, lat);
    checks++; if (bus.alu_result !== 64'h0) begin errors++; $display("FAIL slt_ge got %h exp 0", bus.alu_result); end
    run_op(OP_SLTU, 64'h1, 64'h2, 1'b0, lat);
    checks++; if (bus.alu_result !== 64'h1) begin errors++; $display("FAIL sltu_lt got %h exp 1", bus.alu_result); end
  endtask

  task automatic test_logic;
    int lat;
    run_op(OP_SUB, 64'h5, 64'h7, 1'b0, lat);
    checks++; if (bus.alu_result !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL sub_neg got %h exp fffffffffffffffe", bus.alu_result); end
    run_op(OP_SUB, 64'h0000_0001_0000_0000, 64'h1, 1'b0, lat);
    checks++; if (bus.alu_result !== 64'h0000_0000_FFFF_FFFF) begin errors++; $display("FAIL sub_borrow got %h exp 00000000ffffffff", bus.alu_result); end
    run_op(OP_AND, 64'hF0F0_F0F0_0000_FFFF, 64'hFF00_FF00_FFFF_0F0F, 1'b0, lat);
    checks++; if (bus.alu_result !== 64'hF000_F000_0000_0F0F) begin errors++; $display("FAIL and got %h exp f000f00000000f0f", bus.alu_result); end
    run_op(OP_NOR, 64'hF0F0_F0F0_0000_FFFF, 64'hFF00_FF00_FFFF_0F0F, 1'b0, lat);
    checks++; if (bus.alu_result !== 64'h000F_000F_0000_0000) begin errors++; $display("FAIL nor got %h exp 000f000f00000000", bus.alu_result); end
    run_op(OP_OR, 64'hF0F0_F0F0_0000_FFFF, 64'hFF00_FF00_FFFF_0F0F, 1'b0, lat);
    checks++; if (bus.alu_result !== 64'hFFF0_FFF0_FFFF_FFFF) begin errors++; $display("FAIL or got %h exp fff0fff0ffffffff", bus.alu_result); end
    run_op(OP_XOR, 64'hF0F0_F0F0_0000_FFFF, 64'hFF00_FF00_FFFF_0F0F, 1'b0, lat);
    checks++; if (bus.alu_result !== 64'h0FF0_0FF0_FFFF_F0F0) begin errors++; $display("FAIL xor got %h exp 0ff00ff0fffff0f0", bus.alu_result); end
    run_op(OP_LUI, 64'h0, 64'h1234_5678_9ABC_DEF0, 1'b0, lat);
    checks++; if (bus.alu_result !== 64'h9ABC_DEF0_0000_0000) begin errors++; $display("FAIL lui got %h exp 9abcdef000000000", bus.alu_result); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL lui_latency got %0d exp 3", lat); end
  endtask

  task automatic test_shift;
    int lat;
    run_op(OP_SRA, 64'd63, 64'h8000_0000_0000_0000, 1'b0, lat);
    checks++; if (lat !== 65) begin errors++; $display("FAIL sra63_latency got %0d exp 65", lat); end
    checks++; if (bus.alu_result !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL sra63 got %h exp ffffffffffffffff", bus.alu_result); end
    run_op(OP_SLL, 64'd0, 64'h5, 1'b0, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sll0_latency got %0d exp 2", lat); end
    checks++; if (bus.alu_result !== 64'h5) begin errors++; $display("FAIL sll0 got %h exp 5", bus.alu_result); end
    run_op(OP_SLL, 64'hFFFF_FFFF_FFFF_FFC4, 64'h1, 1'b0, lat);
    checks++; if (lat !== 6) begin errors++; $display("FAIL sll4_latency got %0d exp 6", lat); end
    checks++; if (bus.alu_result !== 64'h10) begin errors++; $display("FAIL sll4 got %h exp 10", bus.alu_result); end
    run_op(OP_SRL, 64'd1, 64'h8000_0000_0000_0000, 1'b0, lat);
    checks++; if (bus.alu_result !== 64'h4000_0000_0000_0000) begin errors++; $display("FAIL srl1 got %h exp 4000000000000000", bus.alu_result); end
  endtask

  task automatic test_illegal;
    int lat;
    run_op(12'h003, 64'h7, 64'h9, 1'b0, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL illegal_latency got %0d exp 1", lat); end
    checks++; if (bus.alu_result !== 64'h0) begin errors++; $display("FAIL illegal_result got %h exp 0", bus.alu_result); end
    checks++; if (bus.illegal !== 1'b1) begin errors++; $display("FAIL illegal_flag got %b exp 1", bus.illegal); end
    run_op(OP_XOR, 64'hF0, 64'hFF, 1'b0, lat);
    checks++; if (bus.illegal !== 1'b0) begin errors++; $display("FAIL illegal_clear got %b exp 0", bus.illegal); end
    checks++; if (bus.alu_result !== 64'h0F) begin errors++; $display("FAIL illegal_next_xor got %h exp f", bus.alu_result); end
    run_op(12'h000, 64'h1, 64'h1, 1'b0, lat);
    checks++; if (bus.illegal !== 1'b1 || lat !== 1) begin errors++; $display("FAIL illegal_zero got %b/%0d exp 1/1", bus.illegal, lat); end
  endtask

  task automatic test_abort;
    int lat;
    int dcnt;
    run_op(OP_OR, 64'hA5, 64'h0, 1'b0, lat);
    dcnt = 0;
    @(negedge clk);
    bus.start       = 1'b1;
    bus.alu_control = OP_SRL;
    bus.alu_src1    = 64'd20;
    bus.alu_src2    = 64'hFFFF_0000_FFFF_0000;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) dcnt++;
      if (c == 5) reset = 1'b1;
    end
    @(negedge clk);
    if (bus.done) dcnt++;
    reset = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", bus.busy); end
    checks++; if (bus.alu_result !== 64'h0) begin errors++; $display("FAIL abort_result got %h exp 0", bus.alu_result); end
    repeat (25) begin
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    checks++; if (dcnt !== 0) begin errors++; $display("FAIL abort_done_count got %0d exp 0", dcnt); end
  endtask

  task automatic test_ignored_start;
    int dcnt;
    dcnt = 0;
    @(negedge clk);
    bus.start       = 1'b1;
    bus.alu_control = OP_ADD;
    bus.alu_src1    = 64'h2;
    bus.alu_src2    = 64'h3;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      bus.start       = (c == 2 || c == 3);
      bus.alu_control = OP_SUB;
      if (bus.done) dcnt++;
    end
    checks++; if (dcnt !== 1) begin errors++; $display("FAIL ignored_start_done_count got %0d exp 1", dcnt); end
    checks++; if (bus.alu_result !== 64'h5) begin errors++; $display("FAIL ignored_start_result got %h exp 5", bus.alu_result); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ignored_start_busy got %b exp 0", bus.busy); end
  endtask

  task automatic test_back_to_back;
    int lat;
    run_op(OP_ADD, 64'h1, 64'h1, 1'b0, lat);
    checks++; if (bus.alu_result !== 64'h2 || lat !== 3) begin errors++; $display("FAIL b2b_first got %h/%0d exp 2/3", bus.alu_result, lat); end
    run_op(OP_OR, 64'h0100, 64'h0011, 1'b0, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL b2b_second_latency got %0d exp 3", lat); end
    checks++; if (bus.alu_result !== 64'h0111) begin errors++; $display("FAIL b2b_second got %h exp 111", bus.alu_result); end
  endtask

  task automatic test_isolation;
    int lat;
    run_op(OP_ADD, 64'd10, 64'd20, 1'b1, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL isolation_latency got %0d exp 3", lat); end
    checks++; if (bus.alu_result !== 64'd30) begin errors++; $display("FAIL isolation_result got %h exp 1e", bus.alu_result); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.alu_control = '0;
    bus.alu_src1 = '0;
    bus.alu_src2 = '0;
    test_reset();
    test_add_carry();
    test_compare();
    test_logic();
    test_shift();
    test_illegal();
    test_abort();
    test_ignored_start();
    test_back_to_back();
    test_isolation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq64.md
ALU_SEQ64 -- requirements
Module: alu_seq64

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have the port start, input, 1 bit: request an operation; sampled only in IDLE.
REQ-004 The block SHALL have the port alu_control, input, 12 bits, one-hot: [11]add [10]sub [9]slt [8]sltu [7]and [6]nor [5]or [4]xor [3]sll [2]srl [1]sra [0]lui.
REQ-005 The block SHALL have the port alu_src1, input, 64 bits: operand 1; for shifts, alu_src1[5:0] is the shift amount.
REQ-006 The block SHALL have the port alu_src2, input, 64 bits: operand 2; for shifts and lui, the value operated on.
REQ-007 The block SHALL have the port busy, output, 1 bit: high in every state except IDLE.
REQ-008 The block SHALL have the port done, output, 1 bit: one-cycle pulse marking alu_result valid.
REQ-009 The block SHALL have the port alu_result, output, 64 bits: registered result, held until the next done.
REQ-010 The block SHALL have the port illegal, output, 1 bit: registered flag, updated with alu_result; set when alu_control was not one-hot.

Function
REQ-011 States SHALL be IDLE, LO, HI, SHIFT and DONE.
REQ-012 In IDLE with start=1, the block SHALL latch alu_control, alu_src1 and alu_src2 into internal registers; later input changes SHALL NOT affect the running operation.
REQ-013 Transitions out of IDLE on start SHALL be:
- to LO for add/sub/slt/sltu/and/nor/or/xor/lui;
- to SHIFT for sll/srl/sra;
- to DONE when the latched control is not one-hot.
REQ-014 LO SHALL compute bits [31:0] through a single 32-bit datapath and register the carry-out, then go to HI.
REQ-015 HI SHALL compute bits [63:32] using the registered carry, then go to DONE.
REQ-016 add SHALL compute src1+src2 mod 2^64.
REQ-017 sub, slt and sltu SHALL compute src1+~src2+1, with carry-in 1 in LO.
REQ-018 slt SHALL produce {63'b0, sign(diff) XOR overflow}.
REQ-019 sltu SHALL produce {63'b0, NOT carry-out of HI}.
REQ-020 Logic ops SHALL be bitwise on 64 bits.
REQ-021 lui SHALL produce {src2[31:0], 32'h0}.
REQ-022 SHIFT SHALL load a 6-bit counter with src1[5:0] and, in each cycle, do one of:
- counter != 0: shift the working value by 1 bit (sll fill 0; srl fill 0; sra fill bit 63) and decrement the counter;
- counter == 0: go to DONE.
REQ-023 DONE SHALL assert done=1 for exactly one cycle and then return to IDLE.
REQ-024 alu_result and illegal SHALL be written on the edge entering DONE.
REQ-025 Illegal control SHALL give alu_result=0 and illegal=1; a legal operation SHALL clear illegal.
REQ-026 Latency SHALL be as follows, with start sampled in cycle 0:
- arithmetic, logic and lui: done in cycle 3;
- shift by N: done in cycle N+2;
- illegal control: done in cycle 1.
REQ-027 start while busy=1, including during DONE, SHALL be ignored and not queued; back-to-back acceptance SHALL be possible in the cycle after DONE.
REQ-028 done and busy SHALL both be high during DONE.

Reset
REQ-029 While reset=1, the block SHALL be forced to IDLE, with busy=0, done=0, alu_result=64'h0, illegal=0 and the counter cleared.
REQ-030 Reset asserted mid-operation SHALL abort the operation with no done pulse; an abort during DONE SHALL also suppress that pulse.
REQ-031 Reset SHALL take priority over start in the same cycle.

Verification
REQ-032 The bench SHALL cover carry propagation: add, src1=64'h0000_0000_FFFF_FFFF, src2=1 -> done in cycle 3, alu_result=64'h0000_0001_0000_0000, illegal=0.
REQ-033 The bench SHALL cover signed and unsigned compare: slt, src1=64'hFFFF_FFFF_FFFF_FFFF, src2=1 -> result=1; sltu on the same operands -> result=0.
REQ-034 The bench SHALL cover shifts:
- sra, src1=63, src2=64'h8000_0000_0000_0000 -> done in cycle 65, result=64'hFFFF_FFFF_FFFF_FFFF;
- sll with shift 0, src2=5 -> done in cycle 2, result=5.
REQ-035 The bench SHALL cover illegal control: alu_control=12'h003 -> done in cycle 1, result=0, illegal=1; a following legal xor clears illegal.
REQ-036 The bench SHALL cover abort and ignored start:
- srl with shift 20 started, reset in cycle 5 -> no done, result=0, busy=0 the next cycle;
- start pulsed while busy -> ignored, exactly one done.
REQ-037 The bench SHALL cover input isolation: change alu_src1/alu_src2 in cycle 1 of an add -> result reflects the operands latched in cycle 0.
